divu_bcd_conv: RTL and testbench
================================

Name: divu_bcd_conv

Overview:
- Sequential binary-to-BCD converter placed directly downstream of the unsigned divider `divu`.
- Takes the divider's WIDTH-bit quotient or remainder and converts it with the shift-add-3 (double-dabble) algorithm, one bit per clock.
- Presents packed BCD digits for the display/readout stage.
- Uses a single-request start/busy/done handshake, so one instance can be time-shared between quotient and remainder.

Parameters:
- WIDTH, 8: bit width of the binary input; matches the divider WIDTH.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; if violated, elaboration stops with $error.

Ports:
- CLK_I  input  1  clock; rising-edge active.
- RST_N_I  input  1  reset; asynchronous, active-low.
- START_I  input  1  conversion request; sampled only while BUSY_O=0.
- BIN_I  input  WIDTH  binary operand; captured on the accepting edge.
- BUSY_O  output  1  high while a conversion is in flight (state != IDLE).
- DONE_O  output  1  one-cycle pulse when BCD_O is updated.
- BCD_O  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]. Held between conversions.

Behaviour:
- Clock and reset: one clock CLK_I. RST_N_I is asynchronous, active-low.
- Reset values: state=IDLE, BUSY_O=0, DONE_O=0, BCD_O=0, internal shift register and counter cleared.
- States:
  - IDLE: START_I=1 at an edge → load shift register {bcd=0, bin=BIN_I}, counter=WIDTH, go to CONVERT.
  - CONVERT: each edge does one iteration and decrements the counter. When the iteration with counter==1 completes: BCD_O ← bcd part, go to DONE.
  - DONE: DONE_O=1 for exactly this cycle; next edge → IDLE unconditionally.
- Iteration, in one cycle:
  - For every 4-bit digit of the bcd part, if the value is >=5, add 3 (4-bit add, no carry between digits).
  - Then shift {bcd,bin} left by 1.
  - After WIDTH iterations, the bcd part equals the decimal value of the captured BIN_I.
- Latency: START accepted at edge E0. BUSY_O=1 from E0 to E(WIDTH+1). BCD_O valid and DONE_O=1 after E(WIDTH), for one cycle.
- Throughput: one result per WIDTH+2 cycles with START_I held high.
- DONE_O and BUSY_O are registered Moore outputs; no combinational path from inputs to outputs.
- START_I while BUSY_O=1, including in the DONE state, is ignored and not queued.
- BIN_I changes after the accepting edge have no effect on the running conversion.
- BCD_O changes only on the edge entering DONE. It holds its value through IDLE and through the following CONVERT, so the old result stays readable during a new conversion.
- Reset mid-conversion: the conversion aborts immediately and asynchronously, all outputs return to reset values, and no DONE pulse is produced.
- Boundary values: BIN_I=0 → all-zero digits; BIN_I=2^WIDTH-1 → correct max value (255 → 12'h255 at defaults). Unused upper digits are 0.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined: on the update into DONE, every leading zero digit above the most significant nonzero digit is replaced by 4'hF (blank code for the seven-segment driver). Digit 0 is never blanked, so value 0 → 12'hFF0.
- Not defined: BCD_O is plain BCD with leading zeros (0 → 12'h000).
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: RST_N_I low 3 ns after t=3 ns, with no clock edge required → BUSY_O=0, DONE_O=0, BCD_O=12'h000.
- Single conversion: BIN_I=8'd9, START_I for 1 cycle → BUSY_O high 9 cycles; DONE_O pulses exactly once, 8 edges after acceptance; BCD_O=12'h009 (12'hFF9 with BCD_BLANK_EN).
- Boundaries: BIN_I=8'd255 → 12'h255. BIN_I=8'd0 → 12'h000 (12'hFF0 with BCD_BLANK_EN). BIN_I=8'd128 → 12'h128.
- Back-to-back: START_I held high, BIN_I=8'd126 → DONE_O pulse every 10 cycles, BCD_O=12'h126 each time, no missed or extra pulses.
- Ignored requests: start 8'd200; during CONVERT change BIN_I to 8'd77 and pulse START_I → result 12'h200, only one DONE_O pulse, previous BCD_O held until that pulse.
- Abort: RST_N_I low during the 4th CONVERT cycle of 8'd99 → outputs cleared immediately, no DONE_O. Then convert 8'd200 → 12'h200 after normal latency.

Source files
------------

// File: rtl/divu_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional build macro BCD_BLANK_EN replaces leading zero digits with 4'hF.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for START_I; BCD_O holds the previous result
// ST_CONVERT | one shift-add-3 iteration per clock, counter counts down
// ST_DONE    | DONE_O high for this single cycle, then back to ST_IDLE
module divu_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic                  START_I,
    input  logic [WIDTH-1:0]      BIN_I,
    output logic                  BUSY_O,
    output logic                  DONE_O,
    output logic [4*DIGITS-1:0]   BCD_O
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
        $error("divu_bcd_conv: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    logic [1:0]    state_q;
    logic [SW-1:0] shift_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [BW-1:0] bcd_q;

    logic [SW-1:0] adj;
    logic [SW-1:0] shift_nxt;
    logic [BW-1:0] bcd_final;
    logic [BW-1:0] bcd_out;

    // Digits are corrected independently; no carry crosses a digit boundary.
    always_comb begin
        adj = shift_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_q[WIDTH + 4*d +: 4] >= 4'd5) begin
                adj[WIDTH + 4*d +: 4] = shift_q[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        shift_nxt = adj << 1;
        bcd_final = shift_nxt[SW-1:WIDTH];
    end

`ifdef BCD_BLANK_EN
    // Blank every zero digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        logic nz;
        bcd_out = bcd_final;
        nz      = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            nz = nz | (bcd_final[4*d +: 4] != 4'd0);
            if (!nz) begin
                bcd_out[4*d +: 4] = 4'hF;
            end
        end
    end
`else
    always_comb begin
        bcd_out = bcd_final;
    end
`endif

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START_I) begin
                        state_q <= ST_CONVERT;
                        shift_q <= {{BW{1'b0}}, BIN_I};
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    shift_q <= shift_nxt;
                    cnt_q   <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        bcd_q   <= bcd_out;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY_O = busy_q;
    assign DONE_O = done_q;
    assign BCD_O  = bcd_q;

endmodule

// File: tb/tb_divu_bcd_conv.sv
// Directed self-checking bench for divu_bcd_conv at default parameters.
// Define BCD_BLANK_EN here as well when the design is built with blanking.
module tb_divu_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int checks   = 0;
    int failures = 0;

`ifdef BCD_BLANK_EN
    localparam logic [11:0] EXP_9 = 12'hFF9;
    localparam logic [11:0] EXP_0 = 12'hFF0;
`else
    localparam logic [11:0] EXP_9 = 12'h009;
    localparam logic [11:0] EXP_0 = 12'h000;
`endif

    divu_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .START_I (start),
        .BIN_I   (bin),
        .BUSY_O  (busy),
        .DONE_O  (done),
        .BCD_O   (bcd)
    );

    // First rising edge at 25 ns so the reset check sees no clock edge.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 ns after an edge with the DUT idle.
    task automatic run_conv(input logic [7:0] val, input logic [11:0] exp, input string tag);
        int          busy_cnt;
        int          done_cnt;
        int          done_idx;
        logic [11:0] bcd_at;
        start = 1'b1;
        bin   = val;
        cyc();
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_idx = -1;
        bcd_at   = 12'hXXX;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_idx = i;
                    bcd_at   = bcd;
                end
            end
        end
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_edge"}, done_idx, 8);
        check({tag, "_bcd"}, bcd_at, exp);
        check({tag, "_bcd_held"}, bcd, exp);
    endtask

    initial begin
        int dcnt;
        int hold_err;
        int bsy;

        rst_n = 1'b1;
        start = 1'b0;
        bin   = 8'd0;

        #3 rst_n = 1'b0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd, 12'h000);
        #6 rst_n = 1'b1;
        cyc();

        run_conv(8'd9, EXP_9, "conv9");
        run_conv(8'd255, 12'h255, "conv255");
        run_conv(8'd0, EXP_0, "conv0");
        run_conv(8'd128, 12'h128, "conv128");

        // Back-to-back: accepted at E0, E10, E20, E30; DONE after E8, E18, E28.
        start = 1'b1;
        bin   = 8'd126;
        dcnt  = 0;
        for (int i = 0; i < 35; i++) begin
            cyc();
            check($sformatf("b2b_done_%0d", i), done, ((i % 10) == 8));
            if (done === 1'b1) begin
                dcnt++;
                check($sformatf("b2b_bcd_%0d", i), bcd, 12'h126);
            end
        end
        check("b2b_pulses", dcnt, 3);
        start = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        check("b2b_drained_busy", busy, 1'b0);

        // Ignored requests: mid-CONVERT change of BIN_I with a START pulse, and START in DONE.
        start    = 1'b1;
        bin      = 8'd200;
        cyc();
        start    = 1'b0;
        dcnt     = 0;
        hold_err = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                start = 1'b1;
                bin   = 8'd77;
            end
            if (i == 4) start = 1'b0;
            if (i == 9) start = 1'b1;
            if (i == 10) start = 1'b0;
            cyc();
            if (i < 8 && bcd !== 12'h126) hold_err++;
            if (done === 1'b1) dcnt++;
            if (i == 8) check("ign_bcd_at_done", bcd, 12'h200);
        end
        check("ign_old_held", hold_err, 0);
        check("ign_done_count", dcnt, 1);
        check("ign_busy_after", busy, 1'b0);
        check("ign_bcd_final", bcd, 12'h200);

        // Abort during the 4th CONVERT cycle of 99.
        start = 1'b1;
        bin   = 8'd99;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bcd", bcd, 12'h000);
        #2 rst_n = 1'b1;
        dcnt = 0;
        bsy  = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bsy++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_no_busy", bsy, 0);
        check("abort_bcd_stays", bcd, 12'h000);

        run_conv(8'd200, 12'h200, "post_abort200");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
